// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, press/release
// pulses, and long-hold detection with periodic auto-repeat.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic pb,
    output logic pb_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic long_hold
);

    // state        | meaning
    // IDLE         | released, waiting for pb_s=1
    // PRESS_WAIT   | debouncing a candidate press
    // PRESSED      | accepted press, counting toward long hold
    // HOLD         | long hold active, emitting repeat pulses
    // RELEASE_WAIT | debouncing a candidate release; hold/repeat counters frozen
    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_PRESS_WAIT   = 3'd1;
    localparam logic [2:0] S_PRESSED      = 3'd2;
    localparam logic [2:0] S_HOLD         = 3'd3;
    localparam logic [2:0] S_RELEASE_WAIT = 3'd4;

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam int RW = $clog2(REPEAT_CYCLES);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic [2:0]    state_q, state_d;
    logic          from_hold_q, from_hold_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] rep_q, rep_d;
    logic          pb_level_q, pb_level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          repeat_q, repeat_d;
    logic          long_hold_q, long_hold_d;
    logic          pb_s;

    assign pb_s = sync2_q;

    always_comb begin
        state_d     = state_q;
        from_hold_d = from_hold_q;
        deb_d       = deb_q;
        hold_d      = hold_q;
        rep_d       = rep_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        repeat_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pb_s) begin
                    state_d = S_PRESS_WAIT;
                    deb_d   = DW'(1);
                end
            end
            S_PRESS_WAIT: begin
                if (!pb_s) begin
                    state_d = S_IDLE;
                    deb_d   = '0;
                end else if (deb_q == DEB_LAST) begin
                    state_d = S_PRESSED;
                    hold_d  = '0;
                    press_d = 1'b1;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            S_PRESSED: begin
                if (!pb_s) begin
                    state_d     = S_RELEASE_WAIT;
                    deb_d       = DW'(1);
                    from_hold_d = 1'b0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d  = S_HOLD;
                    rep_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (!pb_s) begin
                    state_d     = S_RELEASE_WAIT;
                    deb_d       = DW'(1);
                    from_hold_d = 1'b1;
                end else if (rep_q == REP_LAST) begin
                    rep_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    rep_d = rep_q + 1'b1;
                end
            end
            S_RELEASE_WAIT: begin
                // a bounce back to 1 resumes where we left off; counters were never touched
                if (pb_s) begin
                    state_d = from_hold_q ? S_HOLD : S_PRESSED;
                end else if (deb_q == DEB_LAST) begin
                    state_d     = S_IDLE;
                    deb_d       = '0;
                    from_hold_d = 1'b0;
                    release_d   = 1'b1;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                deb_d       = '0;
                from_hold_d = 1'b0;
            end
        endcase

        pb_level_d  = (state_d == S_PRESSED) || (state_d == S_HOLD) ||
                      (state_d == S_RELEASE_WAIT);
        long_hold_d = (state_d == S_HOLD) ||
                      ((state_d == S_RELEASE_WAIT) && from_hold_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= S_IDLE;
            from_hold_q <= 1'b0;
            deb_q       <= '0;
            hold_q      <= '0;
            rep_q       <= '0;
            pb_level_q  <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            repeat_q    <= 1'b0;
            long_hold_q <= 1'b0;
        end else begin
            sync1_q     <= pb;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            from_hold_q <= from_hold_d;
            deb_q       <= deb_d;
            hold_q      <= hold_d;
            rep_q       <= rep_d;
            pb_level_q  <= pb_level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            repeat_q    <= repeat_d;
            long_hold_q <= long_hold_d;
        end
    end

    assign pb_level      = pb_level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;
    assign long_hold     = long_hold_q;

endmodule
